// File: rtl/dflop_ctrl_defs.sv
// ---------------------------------------------------------------------------
// dflop_ctrl_defs
// Shared definitions for the D-flop bank controllers.
//   state_t  : controller FSM encoding (IDLE, LOAD, HOLD, CLEAR)
//   width_of : number of bits needed to represent 0..max_value (minimum 1)
// ---------------------------------------------------------------------------
package dflop_ctrl_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    HOLD  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // A zero-width vector is illegal, so a range of 0..0 or 0..1 still gets
  // one bit.
  function automatic int width_of(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The winner is the first set request bit
// at or above ptr, wrapping modulo N.
// Ports:
//   req     in  [N-1:0]   request vector
//   ptr     in  [IW-1:0]  highest-priority position for this pick
//   onehot  out [N-1:0]   one-hot winner (all zero when no request)
//   idx     out [IW-1:0]  winner index (0 when no request)
//   any_req out           at least one request bit set
// ---------------------------------------------------------------------------
module rr_arbiter
  import dflop_ctrl_defs::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]               req,
  input  logic [width_of(N-1)-1:0]   ptr,
  output logic [N-1:0]               onehot,
  output logic [width_of(N-1)-1:0]   idx,
  output logic                       any_req
);

  localparam int IW = width_of(N - 1);

  int            pos;
  logic [N-1:0]  mask;

  // Walk the requesters in priority order starting at ptr; the first hit
  // wins and later hits are ignored.
  always_comb begin
    any_req = 1'b0;
    idx     = '0;
    pos     = 0;
    mask    = '0;
    for (int k = 0; k < N; k++) begin
      pos  = (int'(ptr) + k) % N;
      mask = N'(1) << pos;
      if (!any_req && (|(req & mask))) begin
        any_req = 1'b1;
        idx     = IW'(pos);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign onehot[gi] = any_req && (idx == IW'(gi));
  end

endmodule

// File: rtl/dflop_bank_ctrl.sv
// ---------------------------------------------------------------------------
// dflop_bank_ctrl
// Shares one W-bit enable/clear D-flop register bank between N requesters.
// Writes are arbitrated round-robin; each load is followed by a hold window
// of HOLD_CYCLES idle cycles; bank clears take priority over writes and hold
// bank_clear_n low for CLR_CYCLES cycles.
// Ports:
//   clk          in                 rising-edge clock
//   reset        in                 synchronous reset, active high
//   req          in  [N-1:0]        per-requester write request
//   req_data     in  [N*W-1:0]      requester i data in bits [i*W +: W]
//   clr_req      in                 clear request (level)
//   bank_en      out                enable to bank flops (high in LOAD)
//   bank_clear_n out                active-low clear to bank flops
//   bank_d       out [W-1:0]        data to bank flops
//   grant        out [N-1:0]        one-hot acknowledge, one cycle in LOAD
//   grant_id     out [$clog2(N)-1:0] index of the last granted requester
//   busy         out                high in any state other than IDLE
// All outputs come from registers or are decoded from registered state.
// ---------------------------------------------------------------------------
module dflop_bank_ctrl
  import dflop_ctrl_defs::*;
#(
  parameter int N           = 4,
  parameter int W           = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int CLR_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [N*W-1:0]        req_data,
  input  logic                  clr_req,
  output logic                  bank_en,
  output logic                  bank_clear_n,
  output logic [W-1:0]          bank_d,
  output logic [N-1:0]          grant,
  output logic [$clog2(N)-1:0]  grant_id,
  output logic                  busy
);

  localparam int IW = width_of(N - 1);
  localparam int CW = width_of((HOLD_CYCLES > CLR_CYCLES) ? HOLD_CYCLES : CLR_CYCLES);

  // The counter counts down to zero, so it is loaded with length-1.
  localparam logic [CW-1:0] HOLD_LOAD = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CLR_LOAD  = CW'(CLR_CYCLES - 1);

  state_t          state_reg, state_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [IW-1:0]   grant_id_reg, grant_id_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [W-1:0]    bank_d_reg, bank_d_next;

  logic [N-1:0]    win_onehot;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  logic [W-1:0]    win_data;

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_reg),
    .onehot  (win_onehot),
    .idx     (win_idx),
    .any_req (win_any)
  );

  // AND-OR data mux driven by the one-hot winner, built as an OR chain.
  logic [W-1:0] data_acc [N+1];
  assign data_acc[0] = '0;
  for (genvar gi = 0; gi < N; gi++) begin : g_data_mux
    assign data_acc[gi+1] = data_acc[gi] | (req_data[gi*W +: W] & {W{win_onehot[gi]}});
  end
  assign win_data = data_acc[N];

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    cnt_next      = cnt_reg;
    bank_d_next   = bank_d_reg;
    grant_id_next = grant_id_reg;

    unique case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next  = CLEAR;
          cnt_next    = CLR_LOAD;
          bank_d_next = '0;
        end else if (win_any) begin
          state_next    = LOAD;
          bank_d_next   = win_data;
          grant_id_next = win_idx;
        end
      end

      LOAD: begin
        // The winner gets lowest priority in the next arbitration.
        ptr_next = (grant_id_reg == IW'(N - 1)) ? '0 : grant_id_reg + 1'b1;
        if (HOLD_CYCLES > 0) begin
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
        end else begin
          state_next = IDLE;
        end
      end

      HOLD: begin
        if (clr_req) begin
          state_next  = CLEAR;
          cnt_next    = CLR_LOAD;
          bank_d_next = '0;
        end else if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      CLEAR: begin
        // Further clear requests are ignored; pending writes wait in IDLE.
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      bank_d_reg   <= '0;
      grant_id_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      cnt_reg      <= cnt_next;
      bank_d_reg   <= bank_d_next;
      grant_id_reg <= grant_id_next;
    end
  end

  // Outputs decoded from registered state only.
  assign bank_en      = (state_reg == LOAD);
  assign bank_clear_n = (state_reg != CLEAR);
  assign busy         = (state_reg != IDLE);
  assign bank_d       = bank_d_reg;
  assign grant_id     = grant_id_reg;

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign grant[gi] = (state_reg == LOAD) && (grant_id_reg == IW'(gi));
  end

endmodule

// File: tb/tb_dflop_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dflop_bank_ctrl
// Directed scenarios plus randomized traffic for dflop_bank_ctrl, checked
// every cycle against a behavioural model that tracks remaining load, hold
// and clear cycles. A second instance (HOLD_CYCLES=0, CLR_CYCLES=3) covers
// back-to-back throughput and reset during a multi-cycle clear.
// ---------------------------------------------------------------------------
module tb_dflop_bank_ctrl;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int HOLD = 2;
  localparam int CLR  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic               reset;
  logic [N-1:0]       req;
  logic [N*W-1:0]     req_data;
  logic               clr_req;
  logic               bank_en, bank_clear_n, busy;
  logic [W-1:0]       bank_d;
  logic [N-1:0]       grant;
  logic [1:0]         grant_id;

  dflop_bank_ctrl #(.N(N), .W(W), .HOLD_CYCLES(HOLD), .CLR_CYCLES(CLR)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .clr_req(clr_req),
    .bank_en(bank_en), .bank_clear_n(bank_clear_n), .bank_d(bank_d),
    .grant(grant), .grant_id(grant_id), .busy(busy)
  );

  // Second instance: no hold window, 3-cycle clear
  logic               reset2;
  logic [N-1:0]       req2;
  logic [N*W-1:0]     req_data2;
  logic               clr2;
  logic               bank_en2, bank_clear_n2, busy2;
  logic [W-1:0]       bank_d2;
  logic [N-1:0]       grant2;
  logic [1:0]         grant_id2;

  dflop_bank_ctrl #(.N(N), .W(W), .HOLD_CYCLES(0), .CLR_CYCLES(3)) u_dut2 (
    .clk(clk), .reset(reset2), .req(req2), .req_data(req_data2), .clr_req(clr2),
    .bank_en(bank_en2), .bank_clear_n(bank_clear_n2), .bank_d(bank_d2),
    .grant(grant2), .grant_id(grant_id2), .busy(busy2)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Log of observed grants (requester index and cycle number)
  int glog[$];
  int gcyc[$];

  // Behavioural model: cycles remaining in each activity
  bit          m_load;
  int          m_hold_left, m_clear_left, m_gid, m_ptr;
  logic [W-1:0] m_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input bit rst, input logic [N-1:0] r, input logic c,
                            input logic [N*W-1:0] dat);
    int  p;
    bit  found;
    if (rst) begin
      m_load = 0; m_hold_left = 0; m_clear_left = 0; m_gid = 0; m_ptr = 0; m_d = '0;
    end else if (m_load) begin
      m_load      = 0;
      m_ptr       = (m_gid + 1) % N;
      m_hold_left = HOLD;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
    end else if (m_hold_left > 0) begin
      if (c) begin
        m_hold_left = 0; m_clear_left = CLR; m_d = '0;
      end else begin
        m_hold_left--;
      end
    end else if (c) begin
      m_clear_left = CLR; m_d = '0;
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (!found && r[p]) begin
          found = 1; m_load = 1; m_gid = p; m_d = dat[p*W +: W];
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_grant;
    exp_grant = m_load ? (N'(1) << m_gid) : '0;
    check("bank_en",      32'(bank_en),      32'(m_load));
    check("bank_clear_n", 32'(bank_clear_n), 32'(m_clear_left == 0));
    check("bank_d",       32'(bank_d),       32'(m_d));
    check("grant",        32'(grant),        32'(exp_grant));
    check("grant_id",     32'(grant_id),     32'(m_gid));
    check("busy",         32'(busy),         32'(m_load || m_hold_left > 0 || m_clear_left > 0));
    for (int j = 0; j < N; j++) begin
      if (grant[j] === 1'b1) begin
        glog.push_back(j);
        gcyc.push_back(cyc);
      end
    end
  endtask

  // One clock: check at the falling edge, then drive the next inputs and
  // advance the model to the state expected after the coming rising edge.
  task automatic cycle(input bit rst, input logic [N-1:0] r, input logic c,
                       input logic [N*W-1:0] dat);
    @(negedge clk);
    cyc++;
    check_outputs();
    $display("[TB] cyc %0d rst=%0b req=%b clr=%0b en=%0b clr_n=%0b d=%h grant=%b id=%0d busy=%0b",
             cyc, rst, r, c, bank_en, bank_clear_n, bank_d, grant, grant_id, busy);
    reset    = rst;
    req      = r;
    clr_req  = c;
    req_data = dat;
    model_step(rst, r, c, dat);
  endtask

  logic [N*W-1:0] dat;
  int             gcount;

  initial begin
    dat = 32'hD3C2B1A0;

    // Second instance held in reset until its own phase
    reset2 = 1'b1; req2 = '0; req_data2 = 32'h44332211; clr2 = 1'b0;

    // ---------------- Reset with all requests and clear asserted --------
    reset = 1'b1; req = 4'b1111; clr_req = 1'b1; req_data = dat;
    model_step(1, 4'b1111, 1'b1, dat);
    cycle(1, 4'b1111, 1'b1, dat);
    cycle(1, 4'b1111, 1'b1, dat);

    // ---------------- Round-robin fairness, first grant to 0 ------------
    glog.delete(); gcyc.delete();
    for (int i = 0; i < 20; i++) cycle(0, 4'b1111, 1'b0, dat);
    check("rr_count_ge5", 32'(glog.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++) check("rr_order", 32'(glog[k]), 32'(k % N));
    for (int k = 0; k < 4; k++) check("rr_spacing", 32'(gcyc[k+1] - gcyc[k]), 32'd4);
    for (int i = 0; i < 6; i++) cycle(0, 4'b0000, 1'b0, dat);

    // ---------------- Single write from requester 2 ---------------------
    dat = 32'h00A50000;
    cycle(0, 4'b0100, 1'b0, dat);
    cycle(0, 4'b0000, 1'b0, dat);
    check("single_en",    32'(bank_en),  32'd1);
    check("single_d",     32'(bank_d),   32'hA5);
    check("single_grant", 32'(grant),    32'b0100);
    check("single_id",    32'(grant_id), 32'd2);
    cycle(0, 4'b0000, 1'b0, dat);
    check("hold1_busy",   32'(busy),     32'd1);
    check("hold1_en",     32'(bank_en),  32'd0);
    cycle(0, 4'b0000, 1'b0, dat);
    check("hold2_busy",   32'(busy),     32'd1);
    cycle(0, 4'b0000, 1'b0, dat);
    check("hold_done",    32'(busy),     32'd0);

    // ---------------- Clear priority over a simultaneous request --------
    dat = 32'h0000005C;
    cycle(0, 4'b0001, 1'b1, dat);
    cycle(0, 4'b0001, 1'b0, dat);
    check("clr_clear_n",  32'(bank_clear_n), 32'd0);
    check("clr_d",        32'(bank_d),       32'd0);
    check("clr_grant",    32'(grant),        32'd0);
    cycle(0, 4'b0001, 1'b0, dat);
    check("clr_1cycle",   32'(bank_clear_n), 32'd1);
    cycle(0, 4'b0000, 1'b0, dat);
    check("after_clr_grant", 32'(grant),     32'b0001);
    check("after_clr_d",     32'(bank_d),    32'h5C);
    for (int i = 0; i < 3; i++) cycle(0, 4'b0000, 1'b0, dat);

    // ---------------- Hold abort by clear -------------------------------
    cycle(0, 4'b0010, 1'b0, dat);
    cycle(0, 4'b0000, 1'b0, dat);
    check("abort_load",   32'(grant),        32'b0010);
    cycle(0, 4'b0000, 1'b1, dat);
    check("abort_in_hold", 32'(busy),        32'd1);
    cycle(0, 4'b0000, 1'b0, dat);
    check("abort_clear_n", 32'(bank_clear_n), 32'd0);
    cycle(0, 4'b0000, 1'b0, dat);
    check("abort_idle",   32'(busy),         32'd0);

    // ---------------- Wrap and withdrawn request ------------------------
    dat = 32'h77665544;
    glog.delete(); gcyc.delete();
    cycle(0, 4'b0100, 1'b0, dat);
    cycle(0, 4'b1001, 1'b0, dat);
    cycle(0, 4'b1011, 1'b0, dat);
    for (int i = 0; i < 9; i++) cycle(0, 4'b1001, 1'b0, dat);
    for (int i = 0; i < 4; i++) cycle(0, 4'b0000, 1'b0, dat);
    check("wrap_count", 32'(glog.size()), 32'd3);
    check("wrap_g0",    32'(glog[0]),     32'd2);
    check("wrap_g1",    32'(glog[1]),     32'd3);
    check("wrap_g2",    32'(glog[2]),     32'd0);

    // ---------------- Randomized traffic --------------------------------
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      r   = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
      dat = $urandom;
      cycle(($urandom_range(0, 63) == 0), r, ($urandom_range(0, 9) == 0), dat);
    end
    cycle(0, 4'b0000, 1'b0, dat);

    // ---------------- Second instance: throughput and reset mid-clear ---
    @(negedge clk);
    reset2 = 1'b0;
    req2   = 4'b0001;
    gcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("tp_grant", 32'(grant2), (i % 2 == 0) ? 32'b0001 : 32'd0);
      check("tp_d",     32'(bank_d2), 32'h11);
      if (grant2 != '0) gcount++;
      $display("[TB] dut2 step %0d grant=%b en=%0b", i, grant2, bank_en2);
    end
    check("tp_count", 32'(gcount), 32'd5);
    req2 = '0;
    clr2 = 1'b1;
    @(negedge clk);
    check("clr3_first",  32'(bank_clear_n2), 32'd0);
    check("clr3_d",      32'(bank_d2),       32'd0);
    clr2 = 1'b0;
    @(negedge clk);
    check("clr3_second", 32'(bank_clear_n2), 32'd0);
    reset2 = 1'b1;
    @(negedge clk);
    check("rst_mid_clr_n", 32'(bank_clear_n2), 32'd1);
    check("rst_mid_busy",  32'(busy2),         32'd0);
    check("rst_mid_en",    32'(bank_en2),      32'd0);
    $display("[TB] dut2 reset mid-clear clear_n=%0b busy=%0b", bank_clear_n2, busy2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dflop_bank_ctrl.md
Name: dflop_bank_ctrl

Overview:
- Shares one W-bit register bank built from enable/clear D flip-flops between N requesters.
- Arbitrates writes round-robin and drives the bank's enable, active-low clear and data.
- Enforces a post-write hold window and services bank-clear requests with priority.
- Sits between requester logic and the register bank; the bank itself is outside this block.

Parameters:
- N, 4: number of requesters (N >= 2).
- W, 8: data width of the bank.
- HOLD_CYCLES, 2: idle cycles forced after each load (0 allowed).
- CLR_CYCLES, 1: cycles bank_clear_n is held low per clear (>= 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- req  input  N  per-requester write request; held until granted.
- req_data  input  N*W  requester i data in bits [i*W +: W].
- clr_req  input  1  request to clear the bank; level, sampled per cycle.
- bank_en  output  1  enable to bank flops.
- bank_clear_n  output  1  active-low clear to bank flops.
- bank_d  output  W  data to bank flops.
- grant  output  N  one-hot, one-cycle acknowledge of the served requester.
- grant_id  output  $clog2(N)  index of the last granted requester.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs registered or decoded from registered state only; no combinational path from inputs to outputs.
- Reset values: state IDLE, rr pointer 0, bank_en 0, bank_clear_n 1, bank_d 0, grant 0, grant_id 0, busy 0, counter 0.
- FSM states: IDLE, LOAD, HOLD, CLEAR.
- IDLE:
  - clr_req=1 at edge -> CLEAR. Clear wins over any req in the same cycle.
  - Else any req bit set -> LOAD. The winner is the first set bit at or above the pointer, wrapping modulo N.
  - Winner's data is latched into bank_d at that edge.
- LOAD, exactly 1 cycle:
  - bank_en=1, grant[winner]=1, grant_id=winner.
  - Pointer <= (winner+1) mod N at exit.
  - Next state: HOLD if HOLD_CYCLES>0, else IDLE.
  - Latency: req sampled at edge E0; bank_en high E0..E1; bank captures at E1.
- HOLD:
  - Counter loaded with HOLD_CYCLES-1 on entry; decrements each cycle; exits to IDLE when it reads 0.
  - bank_en=0.
  - clr_req=1 aborts HOLD -> CLEAR at that edge.
- CLEAR:
  - bank_clear_n=0 for exactly CLR_CYCLES cycles, bank_en=0, then IDLE.
  - bank_d forced to 0 on entry.
  - Pending reqs wait and are not granted during CLEAR.
- Withdrawn requests: a req dropped before the IDLE sample edge is not served. A req dropped during LOAD is still granted, since it was already committed.
- Back-to-back throughput: with HOLD_CYCLES=0 and a continuous req, one grant every 2 cycles (LOAD, IDLE).
- Reset asserted in any state: next edge returns all outputs to reset values. An in-progress clear is truncated and the in-flight grant is dropped.
- Counter width: $clog2(max(HOLD_CYCLES, CLR_CYCLES)+1). Pointer width: $clog2(N).
- bank_d holds its value outside LOAD, except that CLEAR zeroes it.

Decomposition:
- Shared header/package dflop_ctrl_defs holds:
  - state encodings IDLE=2'd0, LOAD=2'd1, HOLD=2'd2, CLEAR=2'd3;
  - the clog2 width helper.
- One sub-module, rr_arbiter:
  - combinational round-robin pick from (req, pointer) -> one-hot winner plus index plus any_req;
  - parameterised by N, reused by other bank controllers.
- FSM, counter and data mux stay in dflop_bank_ctrl.

Test Plan:
- Reset: hold reset 2 cycles with req=4'b1111 and clr_req=1 -> bank_en=0, bank_clear_n=1, grant=0, busy=0 throughout; first grant to requester 0 only after reset deasserts.
- Single write: req=4'b0100, req_data[2]=8'hA5 -> LOAD 1 cycle after sample; bank_en=1, bank_d=8'hA5, grant=4'b0100, grant_id=2; then busy for 2 HOLD cycles.
- Round-robin fairness: req=4'b1111 held, HOLD_CYCLES=2 -> grant order 0,1,2,3,0; exactly 4 cycles between grant pulses.
- Clear priority: clr_req and req=4'b0001 together in IDLE -> CLEAR first, bank_clear_n=0 for 1 cycle, bank_d=0; grant[0] follows after returning to IDLE.
- Hold abort: clr_req pulsed in the first HOLD cycle -> CLEAR at the next edge with no remaining hold cycles; reset mid-CLEAR with CLR_CYCLES=3 -> bank_clear_n=1 on the next edge.
- Wrap and withdraw: pointer at 3, req=4'b1001 -> requester 3 granted, then 0. Requester 1 raises req for one cycle while the FSM is in HOLD -> never granted.
